// File: rtl/sm_0535_uart_pkg.sv
// rtl/sm_0535_uart_pkg.sv - shared UART constants, state encoding and ASCII codes
package sm_0535_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Command characters exchanged between the uart controller and the base station
  localparam logic [BYTE_W-1:0] ASCII_G    = 8'h47;
  localparam logic [BYTE_W-1:0] ASCII_R    = 8'h52;
  localparam logic [BYTE_W-1:0] ASCII_DASH = 8'h2D;
  localparam logic [BYTE_W-1:0] ASCII_HASH = 8'h23;
  localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/sm_0535_sync_bit.sv
// rtl/sm_0535_sync_bit.sv - N-flop single-bit synchronizer with selectable reset value
module sm_0535_sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/sm_0535_uart_receiver.sv
// rtl/sm_0535_uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and valid/ack holding register
module sm_0535_uart_receiver
  import sm_0535_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_data_valid,
  input  logic              rx_ack,
  output logic              rx_frame_err,
  output logic              rx_overrun,
  output logic              rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic rxs;

  sm_0535_sync_bit #(
    .N       (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_reg_q, shift_reg_d;
  logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_reg_d = shift_reg_q;
    rx_byte_d   = rx_byte_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    busy_d      = busy_q;
    armed_d     = armed_q;

    if (rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A start needs a falling edge: a held-low (break) line must rise first
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d   = 1'b0;
          state_d   = ST_START;
          clk_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      ST_START: begin
        if (clk_cnt_q == CNT_MID) begin
          clk_cnt_d = '0;
          if (!rxs) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d              = '0;
          shift_reg_d[bit_idx_q] = rxs;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          if (rxs) begin
            // An ack in this cycle frees the holding register for the new byte
            if (!valid_q || rx_ack) begin
              rx_byte_d = shift_reg_q;
              valid_d   = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_reg_q <= '0;
      rx_byte_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_reg_q <= shift_reg_d;
      rx_byte_q   <= rx_byte_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;
  assign rx_busy       = busy_q;

endmodule
